// File: rtl/dmem_access_ctrl_if.sv
// Bundle of the MEM-stage, debug-dump and RAM-side signals of dmem_access_ctrl.
// Latency: none; wires only.
// Backpressure: carries the dump valid/ready pair; the pipeline side has no backpressure.
interface dmem_access_ctrl_if #(
  parameter int len    = 32,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] i_pipe_addr;
  logic [len-1:0]    i_pipe_wdata;
  logic              i_pipe_we;
  logic              i_pipe_re;
  logic [len-1:0]    o_pipe_rdata;
  logic              i_dbg_start;
  logic [ADDR_W-1:0] i_dbg_base;
  logic [ADDR_W:0]   i_dbg_count;
  logic [len-1:0]    o_dbg_data;
  logic              o_dbg_valid;
  logic              i_dbg_ready;
  logic              o_dbg_done;
  logic              o_busy;
  logic              o_init_done;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [len-1:0]    o_ram_din;
  logic              o_ram_we;
  logic              o_ram_en;
  logic [len-1:0]    i_ram_dout;

  // Environment side: MEM-stage wrapper, debug unit and RAM instance.
  modport master (
    output i_pipe_addr, i_pipe_wdata, i_pipe_we, i_pipe_re,
    output i_dbg_start, i_dbg_base, i_dbg_count, i_dbg_ready, i_ram_dout,
    input  o_pipe_rdata, o_dbg_data, o_dbg_valid, o_dbg_done, o_busy,
    input  o_init_done, o_ram_addr, o_ram_din, o_ram_we, o_ram_en
  );

  // Controller side.
  modport slave (
    input  i_pipe_addr, i_pipe_wdata, i_pipe_we, i_pipe_re,
    input  i_dbg_start, i_dbg_base, i_dbg_count, i_dbg_ready, i_ram_dout,
    output o_pipe_rdata, o_dbg_data, o_dbg_valid, o_dbg_done, o_busy,
    output o_init_done, o_ram_addr, o_ram_din, o_ram_we, o_ram_en
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Shares the single-port data RAM between the MEM stage (always first) and the debug dump engine.
// Latency: pipe access is combinational to the RAM; a dump word takes >=3 cycles (issue, capture, hold).
// Backpressure: dump word held on o_dbg_valid until i_dbg_ready; pipe never stalls. DMEM_ZERO_INIT_EN adds RAM zeroing after reset.
module dmem_access_ctrl #(
  parameter int len       = 32,
  parameter int ADDR_W    = 11,
  parameter int RAM_DEPTH = 2048
) (
  input logic               i_clk,
  input logic               i_rst,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD
`ifdef DMEM_ZERO_INIT_EN
    , INIT
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] dump_addr;
  logic [ADDR_W:0]   rem_cnt;
  logic [len-1:0]    dbg_data_q;
  logic              dbg_valid_q;
  logic              dbg_done_q;
  logic              busy_q;
  logic              pipe_req;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [len-1:0]    ram_din;
`ifdef DMEM_ZERO_INIT_EN
  logic [ADDR_W-1:0] init_addr;
  logic              init_done_q;
`endif

  assign pipe_req = bus.i_pipe_we | bus.i_pipe_re;

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = dump_addr;
    ram_din  = bus.i_pipe_wdata;
    if (pipe_req) begin
      ram_en   = 1'b1;
      ram_we   = bus.i_pipe_we;
      ram_addr = bus.i_pipe_addr;
    end else if (state == ISSUE) begin
      ram_en = 1'b1;
    end
`ifdef DMEM_ZERO_INIT_EN
    // Init owns the port outright; pipeline requests are dropped.
    if (state == INIT) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = init_addr;
      ram_din  = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
`ifdef DMEM_ZERO_INIT_EN
      state       <= INIT;
      busy_q      <= 1'b1;
      init_addr   <= '0;
      init_done_q <= 1'b0;
`else
      state       <= IDLE;
      busy_q      <= 1'b0;
`endif
      dump_addr   <= '0;
      rem_cnt     <= '0;
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
      dbg_done_q  <= 1'b0;
    end else begin
      dbg_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_dbg_start) begin
            if (bus.i_dbg_count != '0) begin
              dump_addr <= bus.i_dbg_base;
              rem_cnt   <= bus.i_dbg_count;
              busy_q    <= 1'b1;
              state     <= ISSUE;
            end else begin
              dbg_done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!pipe_req) state <= CAPTURE;
        end
        CAPTURE: begin
          // RAM output here belongs to last cycle's dump read, whatever the pipe does now.
          dbg_data_q  <= bus.i_ram_dout;
          dbg_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.i_dbg_ready) begin
            dbg_valid_q <= 1'b0;
            dump_addr   <= (dump_addr == LAST_ADDR) ? '0 : dump_addr + ADDR_W'(1);
            rem_cnt     <= rem_cnt - (ADDR_W+1)'(1);
            if (rem_cnt == (ADDR_W+1)'(1)) begin
              dbg_done_q <= 1'b1;
              busy_q     <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
`ifdef DMEM_ZERO_INIT_EN
        INIT: begin
          init_addr <= init_addr + ADDR_W'(1);
          if (init_addr == LAST_ADDR) begin
            init_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ram_en     = ram_en;
  assign bus.o_ram_we     = ram_we;
  assign bus.o_ram_addr   = ram_addr;
  assign bus.o_ram_din    = ram_din;
  assign bus.o_pipe_rdata = bus.i_ram_dout;
  assign bus.o_dbg_data   = dbg_data_q;
  assign bus.o_dbg_valid  = dbg_valid_q;
  assign bus.o_dbg_done   = dbg_done_q;
  assign bus.o_busy       = busy_q;
`ifdef DMEM_ZERO_INIT_EN
  assign bus.o_init_done  = init_done_q;
`else
  assign bus.o_init_done  = 1'b1;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: RAM model plus a word-level reference memory; expected dump beats,
// done pulses and pipe read data are queued at issue time and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;
  localparam int LEN   = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.len(LEN), .ADDR_W(AW)) bus ();

  dmem_access_ctrl #(.len(LEN), .ADDR_W(AW), .RAM_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus.slave)
  );

  // Single-port RAM with 1-cycle synchronous read.
  logic [LEN-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.o_ram_en) begin
      if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_din;
      bus.i_ram_dout <= ram[bus.o_ram_addr];
    end
  end

  // Reference: what each address should hold, and what the dump/pipe owe us.
  logic [LEN-1:0] ref_mem [DEPTH];
  logic [LEN-1:0] beat_q[$];
  logic [LEN-1:0] pipe_q[$];
  int             done_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int last_beat_cyc = -100;
  int done_seen = 0;
  int ready_mode = 0;
  int stall = 0;
  int mon_n;
  logic held = 1'b0;
  logic [LEN-1:0] held_dat;
  logic done_prev = 1'b0;
  logic prev_pipe_rd = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Ready driver: 0 always ready, 1 random, 2 four-cycle stall per beat, 3 never ready.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.i_dbg_ready = 1'b1;
      1: bus.i_dbg_ready = 1'($urandom_range(0, 1));
      2: begin
        if (bus.o_dbg_valid && stall < 4) begin
          bus.i_dbg_ready = 1'b0;
          stall++;
        end else begin
          bus.i_dbg_ready = bus.o_dbg_valid;
          if (!bus.o_dbg_valid) stall = 0;
        end
      end
      default: bus.i_dbg_ready = 1'b0;
    endcase
  end

  // Monitor: inputs are stable from posedge+1 to the next posedge, so negedge sees the handshake.
  always @(negedge clk) begin
    cyc++;
    if (prev_pipe_rd) begin
      chk("pipe_rd_expected", longint'(pipe_q.size() != 0), 1);
      if (pipe_q.size() != 0) chk("pipe_rdata", bus.o_pipe_rdata, pipe_q.pop_front());
    end
    prev_pipe_rd = rst_n && bus.i_pipe_re && !bus.i_pipe_we && bus.o_init_done;

    if (held && rst_n) begin
      chk("hold_valid", bus.o_dbg_valid, 1);
      chk("hold_data", bus.o_dbg_data, held_dat);
    end
    held = 1'b0;
    if (bus.o_dbg_valid) begin
      if (bus.i_dbg_ready) begin
        chk("beat_expected", longint'(beat_q.size() != 0), 1);
        if (beat_q.size() != 0) chk("dump_data", bus.o_dbg_data, beat_q.pop_front());
        last_beat_cyc = cyc;
      end else begin
        held = 1'b1;
        held_dat = bus.o_dbg_data;
      end
    end

    if (bus.o_dbg_done) begin
      chk("done_width", done_prev, 0);
      chk("done_expected", longint'(done_q.size() != 0), 1);
      if (done_q.size() != 0) begin
        mon_n = done_q.pop_front();
        if (mon_n != 0) chk("done_timing", cyc - last_beat_cyc, 1);
        chk("done_beats_left", beat_q.size(), 0);
      end
      done_seen++;
    end
    done_prev = bus.o_dbg_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_write(input logic [AW-1:0] a, input logic [LEN-1:0] d, input bit chk_mux);
    bit live;
    live = bus.o_init_done;
    bus.i_pipe_we = 1'b1;
    bus.i_pipe_addr = a;
    bus.i_pipe_wdata = d;
    if (chk_mux) begin
      #1;
      chk("wr_en", bus.o_ram_en, 1);
      chk("wr_we", bus.o_ram_we, 1);
      chk("wr_addr", bus.o_ram_addr, a);
      chk("wr_din", bus.o_ram_din, d);
    end
    tick();
    bus.i_pipe_we = 1'b0;
    if (live) ref_mem[a] = d;
  endtask

  task automatic pipe_read(input logic [AW-1:0] a);
    bus.i_pipe_re = 1'b1;
    bus.i_pipe_addr = a;
    if (bus.o_init_done) pipe_q.push_back(ref_mem[a]);
    tick();
    bus.i_pipe_re = 1'b0;
  endtask

  task automatic dump_start(input int base, input int count);
    bus.i_dbg_start = 1'b1;
    bus.i_dbg_base  = AW'(base);
    bus.i_dbg_count = (AW+1)'(count);
    for (int i = 0; i < count; i++) beat_q.push_back(ref_mem[(base + i) % DEPTH]);
    done_q.push_back(count);
    tick();
    bus.i_dbg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_pipe);
    int s;
    int n;
    s = done_seen;
    n = 0;
    while (done_seen == s && n < budget) begin
      if (rand_pipe) begin
        bus.i_pipe_re = 1'($urandom_range(0, 1));
        bus.i_pipe_addr = AW'($urandom_range(0, DEPTH - 1));
        if (bus.i_pipe_re) pipe_q.push_back(ref_mem[bus.i_pipe_addr]);
      end
      tick();
      n++;
    end
    bus.i_pipe_re = 1'b0;
    chk("done_in_time", longint'(done_seen != s), 1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!bus.o_dbg_valid && n < budget) begin
      tick();
      n++;
    end
    chk("valid_in_time", bus.o_dbg_valid, 1);
  endtask

  task automatic wait_init();
`ifdef DMEM_ZERO_INIT_EN
    int n;
    n = 0;
    while (!bus.o_init_done && n < 3000) begin
      // A pipe write mid-init must not reach the RAM.
      bus.i_pipe_we = (n == 10);
      bus.i_pipe_addr = AW'(7);
      bus.i_pipe_wdata = 32'h1234_5678;
      if (n == 10) begin
        #1;
        chk("init_din", bus.o_ram_din, 0);
        chk("init_busy", bus.o_busy, 1);
      end
      tick();
      n++;
    end
    bus.i_pipe_we = 1'b0;
    chk("init_cycles", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    pipe_read(AW'(7));
`endif
  endtask

  initial begin
    logic [LEN-1:0] abc [3];
    abc[0] = 32'hA; abc[1] = 32'hB; abc[2] = 32'hC;
    bus.i_pipe_addr = '0; bus.i_pipe_wdata = '0; bus.i_pipe_we = 1'b0; bus.i_pipe_re = 1'b0;
    bus.i_dbg_start = 1'b0; bus.i_dbg_base = '0; bus.i_dbg_count = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    #22;
    chk("rst_valid", bus.o_dbg_valid, 0);
    chk("rst_done", bus.o_dbg_done, 0);
    chk("rst_data", bus.o_dbg_data, 0);
    chk("rst_we", bus.o_ram_we, 0);
`ifdef DMEM_ZERO_INIT_EN
    chk("rst_busy", bus.o_busy, 1);
    chk("rst_init_done", bus.o_init_done, 0);
`else
    chk("rst_en", bus.o_ram_en, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_init_done", bus.o_init_done, 1);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init();

    // Fill every word through the pipe so RAM and reference agree everywhere.
    for (int a = 0; a < DEPTH; a++) pipe_write(AW'(a), $urandom, a < 2);
    pipe_write(AW'(5), 32'hDEAD_BEEF, 1'b1);
    pipe_read(AW'(5));
    for (int i = 0; i < 3; i++) pipe_write(AW'(4 + i), abc[i], 1'b0);

    ready_mode = 0;
    dump_start(4, 3);
    chk("busy_dump", bus.o_busy, 1);
    wait_done(50, 1'b0);
    chk("busy_after", bus.o_busy, 0);

    // Pipe holds the port for 5 cycles while the dump sits in ISSUE.
    dump_start(300, 3);
    for (int k = 0; k < 5; k++) begin
      bus.i_pipe_re = 1'b1;
      bus.i_pipe_addr = AW'(20 + k);
      pipe_q.push_back(ref_mem[20 + k]);
      #1;
      chk("cont_addr", bus.o_ram_addr, 20 + k);
      chk("cont_we", bus.o_ram_we, 0);
      tick();
    end
    bus.i_pipe_re = 1'b0;
    #1;
    chk("resume_en", bus.o_ram_en, 1);
    chk("resume_addr", bus.o_ram_addr, 300);
    wait_done(50, 1'b0);

    // Backpressure across the top-of-memory wrap, with a stray start during HOLD.
    ready_mode = 2;
    dump_start(DEPTH - 2, 4);
    wait_valid(20);
    bus.i_dbg_start = 1'b1;
    bus.i_dbg_base = '0;
    bus.i_dbg_count = 12'd7;
    tick();
    bus.i_dbg_start = 1'b0;
    wait_done(200, 1'b0);
    chk("busy_wrap", bus.o_busy, 0);

    // Zero-length dump.
    ready_mode = 0;
    dump_start(9, 0);
    chk("busy_cnt0", bus.o_busy, 0);
    wait_done(5, 1'b0);
    chk("busy_cnt0_after", bus.o_busy, 0);

    // Reset while a word is held.
    ready_mode = 3;
    dump_start(100, 5);
    wait_valid(20);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.o_dbg_valid, 0);
    chk("midrst_done", bus.o_dbg_done, 0);
    beat_q.delete();
    done_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    wait_init();
    repeat (10) tick();
    chk("midrst_busy", bus.o_busy, 0);

    // Random dumps against random ready and competing pipe reads.
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      dump_start((r % 3 == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1) : $urandom_range(0, DEPTH - 1),
                 $urandom_range(1, 12));
      wait_done(600, 1'b1);
    end

    // Whole memory, wrapping from a random base.
    ready_mode = 0;
    dump_start($urandom_range(0, DEPTH - 1), DEPTH);
    wait_done(8000, 1'b0);

    repeat (3) tick();
    chk("beats_left", beat_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    chk("pipe_left", pipe_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
